// File: rtl/lc3_regfile_param_if.sv
// rtl/lc3_regfile_param_if.sv - bus bundle between the LC3 core/debug side and the register file
// Purpose: groups the write, read, view and dump-stream signals of lc3_regfile_param.
// Ports (signal groups):
//   write : Wr_En, Wr_Addr[AW], Wr_Data[WIDTH]
//   read  : Rd1_Addr/Rd1_Data, Rd2_Addr/Rd2_Data, View_Addr/View_Data
//   dump  : Dump_Start, Dump_Ready (to regfile); Dump_Busy, Dump_Valid, Dump_Addr,
//           Dump_Data, Dump_Last (from regfile)
// Modports: master = core/consumer side, slave = register file.
interface lc3_regfile_param_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             Wr_En;
  logic [AW-1:0]    Wr_Addr;
  logic [WIDTH-1:0] Wr_Data;
  logic [AW-1:0]    Rd1_Addr;
  logic [WIDTH-1:0] Rd1_Data;
  logic [AW-1:0]    Rd2_Addr;
  logic [WIDTH-1:0] Rd2_Data;
  logic [AW-1:0]    View_Addr;
  logic [WIDTH-1:0] View_Data;
  logic             Dump_Start;
  logic             Dump_Busy;
  logic             Dump_Valid;
  logic             Dump_Ready;
  logic [AW-1:0]    Dump_Addr;
  logic [WIDTH-1:0] Dump_Data;
  logic             Dump_Last;

  modport master (
    output Wr_En, Wr_Addr, Wr_Data, Rd1_Addr, Rd2_Addr, View_Addr, Dump_Start, Dump_Ready,
    input  Rd1_Data, Rd2_Data, View_Data, Dump_Busy, Dump_Valid, Dump_Addr, Dump_Data, Dump_Last
  );

  modport slave (
    input  Wr_En, Wr_Addr, Wr_Data, Rd1_Addr, Rd2_Addr, View_Addr, Dump_Start, Dump_Ready,
    output Rd1_Data, Rd2_Data, View_Data, Dump_Busy, Dump_Valid, Dump_Addr, Dump_Data, Dump_Last
  );
endinterface

// File: rtl/lc3_regfile_param.sv
// rtl/lc3_regfile_param.sv - parametrised LC3 register file with handshaked dump engine
// Purpose: DEPTH x WIDTH register storage with one write port, two combinational operand
//   read ports, a never-bypassed debug view port, and an IDLE/SEND engine that streams every
//   register in address order over a valid/ready handshake without blocking writes.
// Ports:
//   Clk   : clock, rising edge
//   Reset : asynchronous, active-low reset
//   bus   : lc3_regfile_param_if.slave (write, read, view and dump-stream signals)
// Build option: define REGFILE_BYPASS_EN to forward Wr_Data to Rd1_Data/Rd2_Data in the
//   cycle of a matching valid write; View_Data and the dump stream are never forwarded.
module lc3_regfile_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               Clk,
  input  logic               Reset,
  lc3_regfile_param_if.slave bus
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SEND  = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] dump_data_q, dump_data_d;

  logic             wr_ok;
  logic [AW-1:0]    ptr_nxt;
  logic             dump_valid;
  logic             dump_last;

  // DEPTH need not be a power of two, so addresses above DEPTH-1 are decoded as holes.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic [WIDTH-1:0] rd_reg(input logic [AW-1:0] a);
    if (addr_ok(a)) return regs_q[a];
    return '0;
  endfunction

  assign wr_ok      = bus.Wr_En && addr_ok(bus.Wr_Addr);
  assign ptr_nxt    = ptr_q + AW'(1);
  assign dump_valid = (state_q == ST_SEND);
  assign dump_last  = dump_valid && (ptr_q == LAST_IDX);

  // Storage update: writes are never held off by the dump engine.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    if (wr_ok) regs_d[bus.Wr_Addr] = bus.Wr_Data;
  end

  // Dump engine. Captures read regs_q, i.e. the value before this edge's write.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dump_data_d = dump_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Dump_Start) begin
          state_d     = ST_SEND;
          ptr_d       = '0;
          dump_data_d = regs_q[0];
        end
      end
      default: begin
        if (bus.Dump_Ready) begin
          if (dump_last) begin
            // Start in this same cycle is deliberately not looked at.
            state_d     = ST_IDLE;
            ptr_d       = '0;
            dump_data_d = '0;
          end else begin
            ptr_d       = ptr_nxt;
            dump_data_d = regs_q[ptr_nxt];
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      dump_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dump_data_q <= dump_data_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign bus.Rd1_Data = (wr_ok && (bus.Rd1_Addr == bus.Wr_Addr)) ? bus.Wr_Data : rd_reg(bus.Rd1_Addr);
  assign bus.Rd2_Data = (wr_ok && (bus.Rd2_Addr == bus.Wr_Addr)) ? bus.Wr_Data : rd_reg(bus.Rd2_Addr);
`else
  assign bus.Rd1_Data = rd_reg(bus.Rd1_Addr);
  assign bus.Rd2_Data = rd_reg(bus.Rd2_Addr);
`endif
  assign bus.View_Data  = rd_reg(bus.View_Addr);

  assign bus.Dump_Busy  = dump_valid;
  assign bus.Dump_Valid = dump_valid;
  assign bus.Dump_Last  = dump_last;
  assign bus.Dump_Addr  = ptr_q;
  assign bus.Dump_Data  = dump_data_q;

endmodule
